// File: rtl/ltc2387_cnv_scheduler.sv
// Conversion scheduler for the LTC2387 deserializer: owns the free-running timestamp,
// arm/trigger/abort control and periodic or burst start pacing against adc_ready.
module ltc2387_cnv_scheduler #(
  parameter int TS_WIDTH   = 64,
  parameter int MIN_PERIOD = 17,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk_cnv,
  input  logic                 rst,
  input  logic                 ts_load,
  input  logic [TS_WIDTH-1:0]  ts_load_value,
  output logic [TS_WIDTH-1:0]  ts,
  input  logic [7:0]           cfg_period,
  input  logic                 cfg_burst,
  input  logic [CNT_WIDTH-1:0] cfg_burst_len,
  input  logic                 trig_sel,
  input  logic                 arm,
  input  logic                 sw_trig,
  input  logic                 ext_trig,
  input  logic                 abort,
  input  logic                 adc_ready,
  output logic                 start,
  output logic [7:0]           sample_rate,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] missed_count,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [7:0]           MIN_P    = 8'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               st;
  logic                 ext_prev;
  logic                 pending;
  logic [7:0]           period_cnt;
  logic                 burst_mode;
  logic [CNT_WIDTH-1:0] burst_len;

  logic                 trig;
  logic [7:0]           eff_period;
  logic                 tick;
  logic                 issue;
  logic                 burst_full;
  logic                 burst_last;
  logic [CNT_WIDTH-1:0] sample_inc;
  logic [CNT_WIDTH-1:0] missed_inc;

  assign state      = st;
  assign trig       = trig_sel ? (ext_trig & ~ext_prev) : sw_trig;
  assign eff_period = (cfg_period < MIN_P) ? MIN_P : cfg_period;
  assign tick       = (period_cnt == 8'd0);
  // One idle cycle is forced between starts so a refill can never produce back-to-back requests.
  assign issue      = pending & adc_ready & ~start;
  assign sample_inc = (sample_count == CNT_MAX) ? CNT_MAX : sample_count + CNT_ONE;
  assign missed_inc = (missed_count == CNT_MAX) ? CNT_MAX : missed_count + CNT_ONE;
  assign burst_full = burst_mode & (sample_count >= burst_len);
  assign burst_last = burst_mode & (sample_inc >= burst_len);

  always_ff @(posedge clk_cnv) begin
    if (rst) begin
      st           <= S_IDLE;
      ts           <= '0;
      ext_prev     <= 1'b0;
      pending      <= 1'b0;
      period_cnt   <= '0;
      burst_mode   <= 1'b0;
      burst_len    <= '0;
      start        <= 1'b0;
      sample_rate  <= MIN_P;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
      missed_count <= '0;
    end else begin
      ext_prev <= ext_trig;
      ts       <= ts_load ? ts_load_value : ts + TS_WIDTH'(1);
      start    <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        st      <= S_IDLE;
        pending <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            if (arm) begin
              st           <= S_ARMED;
              busy         <= 1'b1;
              sample_count <= '0;
              missed_count <= '0;
            end
          end
          S_ARMED: begin
            if (trig) begin
              st          <= S_RUN;
              sample_rate <= eff_period;
              period_cnt  <= eff_period - 8'd1;
              pending     <= 1'b1;
              burst_mode  <= cfg_burst;
              burst_len   <= cfg_burst_len;
            end
          end
          S_RUN: begin
            // Covers a zero-length burst: leave without issuing anything.
            if (burst_full) begin
              st      <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pending <= 1'b0;
            end else begin
              period_cnt <= tick ? sample_rate - 8'd1 : period_cnt - 8'd1;
              if (issue) begin
                start        <= 1'b1;
                sample_count <= sample_inc;
                if (burst_last) begin
                  st   <= S_DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
                end
              end
              if (tick) begin
                pending <= 1'b1;
                if (pending && !issue) missed_count <= missed_inc;
              end else if (issue) begin
                pending <= 1'b0;
              end
            end
          end
          default: begin
            st <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ltc2387_cnv_scheduler.sv
// Directed bench for ltc2387_cnv_scheduler: timestamp, continuous, burst, missed ticks,
// abort and zero-length burst scenarios, each checked against hand-computed cycle offsets.
module tb_ltc2387_cnv_scheduler;

  logic        clk_cnv = 1'b0;
  logic        rst = 1'b1;
  logic        ts_load = 1'b0;
  logic [63:0] ts_load_value = '0;
  logic [63:0] ts;
  logic [7:0]  cfg_period = 8'd0;
  logic        cfg_burst = 1'b0;
  logic [31:0] cfg_burst_len = '0;
  logic        trig_sel = 1'b0;
  logic        arm = 1'b0;
  logic        sw_trig = 1'b0;
  logic        ext_trig = 1'b0;
  logic        abort = 1'b0;
  logic        adc_ready = 1'b1;
  logic        start;
  logic [7:0]  sample_rate;
  logic        busy;
  logic        done;
  logic [31:0] sample_count;
  logic [31:0] missed_count;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  ltc2387_cnv_scheduler dut (
    .clk_cnv(clk_cnv), .rst(rst), .ts_load(ts_load), .ts_load_value(ts_load_value), .ts(ts),
    .cfg_period(cfg_period), .cfg_burst(cfg_burst), .cfg_burst_len(cfg_burst_len),
    .trig_sel(trig_sel), .arm(arm), .sw_trig(sw_trig), .ext_trig(ext_trig), .abort(abort),
    .adc_ready(adc_ready), .start(start), .sample_rate(sample_rate), .busy(busy), .done(done),
    .sample_count(sample_count), .missed_count(missed_count), .state(state)
  );

  always #2 clk_cnv = ~clk_cnv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_cnv);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic abort_pulse();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (ts !== 64'd0) begin fails++; $display("FAIL reset_ts: got %0h expected 0", ts); end
    tests++; if (sample_rate !== 8'd17) begin fails++; $display("FAIL reset_rate: got %0d expected 17", sample_rate); end
    tests++; if ({start, busy, done} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {start, busy, done}); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    rst = 1'b0;
    step();
    tests++; if (ts !== 64'd1) begin fails++; $display("FAIL ts_run: got %0h expected 1", ts); end
    ts_load = 1'b1;
    ts_load_value = 64'h100;
    step();
    ts_load = 1'b0;
    tests++; if (ts !== 64'h100) begin fails++; $display("FAIL ts_load: got %0h expected 100", ts); end
    step();
    tests++; if (ts !== 64'h101) begin fails++; $display("FAIL ts_inc: got %0h expected 101", ts); end
  endtask

  task automatic test_continuous();
    cfg_period = 8'd5; cfg_burst = 1'b0; trig_sel = 1'b0; adc_ready = 1'b1;
    arm_pulse();
    tests++; if (state !== 2'd1 || busy !== 1'b1) begin fails++; $display("FAIL cont_armed: got state %0d busy %b expected 1 1", state, busy); end
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL cont_run: got %0d expected 2", state); end
    tests++; if (sample_rate !== 8'd17) begin fails++; $display("FAIL cont_rate: got %0d expected 17", sample_rate); end
    for (int t = 1; t <= 60; t++) begin
      step();
      tests++; if (start !== ((t % 17) == 1)) begin fails++; $display("FAIL cont_start t=%0d: got %b expected %b", t, start, (t % 17) == 1); end
    end
    tests++; if (sample_count !== 32'd4) begin fails++; $display("FAIL cont_count: got %0d expected 4", sample_count); end
    tests++; if (missed_count !== 32'd0) begin fails++; $display("FAIL cont_missed: got %0d expected 0", missed_count); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL cont_busy: got %b expected 1", busy); end
    abort_pulse();
    tests++; if (state !== 2'd0 || busy !== 1'b0) begin fails++; $display("FAIL cont_abort: got state %0d busy %b expected 0 0", state, busy); end
  endtask

  task automatic test_burst_ext();
    cfg_period = 8'd40; cfg_burst = 1'b1; cfg_burst_len = 32'd3; trig_sel = 1'b1; ext_trig = 1'b0;
    step();
    arm_pulse();
    tests++; if (sample_count !== 32'd0) begin fails++; $display("FAIL burst_arm_clear: got %0d expected 0", sample_count); end
    ext_trig = 1'b1;
    step();
    tests++; if (state !== 2'd2 || sample_rate !== 8'd40) begin fails++; $display("FAIL burst_entry: got state %0d rate %0d expected 2 40", state, sample_rate); end
    for (int t = 1; t <= 100; t++) begin
      step();
      if (t == 5) ext_trig = 1'b0;
      tests++; if (start !== (t == 1 || t == 41 || t == 81)) begin fails++; $display("FAIL burst_start t=%0d: got %b expected %b", t, start, (t == 1 || t == 41 || t == 81)); end
      tests++; if (done !== (t == 81)) begin fails++; $display("FAIL burst_done t=%0d: got %b expected %b", t, done, t == 81); end
    end
    tests++; if (busy !== 1'b0 || state !== 2'd0) begin fails++; $display("FAIL burst_idle: got busy %b state %0d expected 0 0", busy, state); end
    tests++; if (sample_count !== 32'd3) begin fails++; $display("FAIL burst_count: got %0d expected 3", sample_count); end
  endtask

  task automatic test_missed();
    cfg_period = 8'd20; cfg_burst = 1'b0; trig_sel = 1'b0; adc_ready = 1'b1;
    arm_pulse();
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    for (int t = 1; t <= 62; t++) begin
      adc_ready = ((t - 1) >= 45);
      step();
      tests++; if (start !== (t == 46 || t == 61)) begin fails++; $display("FAIL miss_start t=%0d: got %b expected %b", t, start, (t == 46 || t == 61)); end
      if (t == 50) begin
        tests++; if (missed_count !== 32'd2) begin fails++; $display("FAIL miss_count: got %0d expected 2", missed_count); end
        tests++; if (sample_count !== 32'd1) begin fails++; $display("FAIL miss_samples: got %0d expected 1", sample_count); end
      end
    end
    abort_pulse();
  endtask

  task automatic test_abort();
    cfg_period = 8'd20; cfg_burst = 1'b1; cfg_burst_len = 32'd5; trig_sel = 1'b0; adc_ready = 1'b1;
    arm_pulse();
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    for (int t = 1; t <= 10; t++) step();
    abort_pulse();
    tests++; if (state !== 2'd0 || busy !== 1'b0) begin fails++; $display("FAIL abort_state: got state %0d busy %b expected 0 0", state, busy); end
    for (int t = 0; t < 40; t++) begin
      step();
      tests++; if (start !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_quiet t=%0d: got start %b done %b expected 0 0", t, start, done); end
    end
    tests++; if (sample_count !== 32'd1) begin fails++; $display("FAIL abort_count: got %0d expected 1", sample_count); end
  endtask

  task automatic test_burst_zero();
    cfg_period = 8'd20; cfg_burst = 1'b1; cfg_burst_len = 32'd0; trig_sel = 1'b0; adc_ready = 1'b1;
    arm_pulse();
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    tests++; if (done !== 1'b0 || start !== 1'b0) begin fails++; $display("FAIL zero_t0: got done %b start %b expected 0 0", done, start); end
    step();
    tests++; if (done !== 1'b1 || start !== 1'b0) begin fails++; $display("FAIL zero_done: got done %b start %b expected 1 0", done, start); end
    step();
    tests++; if (done !== 1'b0 || state !== 2'd0) begin fails++; $display("FAIL zero_end: got done %b state %0d expected 0 0", done, state); end
    tests++; if (sample_count !== 32'd0) begin fails++; $display("FAIL zero_count: got %0d expected 0", sample_count); end
  endtask

  task automatic test_ext_held();
    cfg_burst = 1'b0; trig_sel = 1'b1; ext_trig = 1'b1;
    step();
    step();
    arm_pulse();
    for (int t = 0; t < 5; t++) step();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL held_no_trig: got %0d expected 1", state); end
    ext_trig = 1'b0;
    step();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL held_fall: got %0d expected 1", state); end
    ext_trig = 1'b1;
    step();
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL held_edge: got %0d expected 2", state); end
    step();
    tests++; if (start !== 1'b1) begin fails++; $display("FAIL held_start: got %b expected 1", start); end
    abort_pulse();
    ext_trig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst_ext();
    test_missed();
    test_abort();
    test_burst_zero();
    test_ext_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
